xlat_req_queue: RTL and testbench
=================================

# xlat_req_queue

Translation requester sitting directly upstream of the vector MMU port: it accepts virtual addresses from the vector address generator, issues one-outstanding requests to the MMU, and collects physical address/exception results into a small in-order FIFO for the downstream memory-request stage. It halts on the first page fault or response timeout until explicitly flushed. A bypass path handles translation-disabled operation without touching the MMU.

## Interface
- DEPTH, 4: result FIFO entries (>=1).
- TIMEOUT, 64: max cycles to wait for mmu_valid_i after a request (>=2).
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- en_translation_i  in  1  1: translate via MMU; 0: bypass (paddr = vaddr truncated to PLEN).
- flush_i  in  1  discard FIFO contents and leave HALT.
- req_valid_i / req_ready_o  in/out  1  upstream handshake.
- req_vaddr_i  in  riscv::VLEN  virtual address.
- req_is_store_i  in  1  store (1) / load (0).
- mmu_req_o  out  1  single-cycle MMU request strobe.
- mmu_vaddr_o  out  riscv::VLEN  address to MMU, valid with mmu_req_o.
- mmu_is_store_o  out  1  access type to MMU, valid with mmu_req_o.
- mmu_valid_i  in  1  MMU result valid (one cycle).
- mmu_paddr_i  in  riscv::PLEN  translated address.
- mmu_exception_i  in  ariane_pkg::exception_t  fault info, sampled with mmu_valid_i.
- resp_valid_o / resp_ready_i  out/in  1  downstream handshake.
- resp_paddr_o  out  riscv::PLEN  FIFO head physical address.
- resp_exception_o  out  ariane_pkg::exception_t  FIFO head exception ('0 if none).
- halted_o  out  1  block is in HALT.
- timeout_o  out  1  sticky, set by response timeout, cleared by flush_i.

## Operation
- States: IDLE, WAIT, HALT, FLUSH.
- IDLE, translation on: req_ready_o = (count < DEPTH) & ~flush_i. On handshake: mmu_req_o=1 same cycle with mmu_vaddr_o=req_vaddr_i, mmu_is_store_o=req_is_store_i; latch vaddr; timer cleared; go WAIT.
- IDLE, bypass: same ready rule; on handshake push {vaddr[PLEN-1:0], '0 exception} same cycle; stay IDLE; mmu_req_o=0.
- WAIT: req_ready_o=0, mmu_req_o=0. On mmu_valid_i push {mmu_paddr_i, mmu_exception_i}; if exception.valid go HALT else IDLE. No new request issued in the cycle mmu_valid_i is seen (MMU cannot accept back-to-back). Timer increments each cycle; at timer==TIMEOUT-1 without mmu_valid_i: set timeout_o, go HALT, nothing pushed.
- HALT: req_ready_o=0, halted_o=1; FIFO continues draining downstream. flush_i: clear FIFO, clear timeout_o, go IDLE.
- flush_i in IDLE: clear FIFO, stay IDLE. flush_i in WAIT: clear FIFO, go FLUSH. FLUSH: req_ready_o=0; next mmu_valid_i (or timer expiry) is discarded, go IDLE. Flush has priority over push and pop in the same cycle.
- FIFO: in-order, count width $clog2(DEPTH+1). Push and pop in same cycle: count unchanged. Slot reserved at issue (count<DEPTH checked in IDLE; only this block pushes), so push never overflows. resp_valid_o = (count != 0).
- en_translation_i sampled only at IDLE handshake; changes during WAIT do not affect the outstanding request.

## Timing
- Reset (rst_i high at clock edge): state IDLE, count 0, timer 0, timeout_o 0. While rst_i is high, req_ready_o, mmu_req_o, resp_valid_o forced 0; halted_o 0; resp_paddr_o/resp_exception_o '0.
- Translated latency: handshake cycle N, MMU valid N+1 (stub-class MMU) -> entry visible at resp_valid_o in N+2.
- Sustained translated throughput: one request per 2 cycles with 1-cycle MMU; one per (latency+1) in general.
- Bypass: handshake cycle N -> resp_valid_o in N+1; one request per cycle while not full.
- req_ready_o combinational on count/state/flush_i only, never on req_valid_i.

## Test plan
- Translation on, 1-cycle MMU, vaddrs 0x1000,0x2000,0x3000, resp_ready_i=1 -> mmu_req_o pulses at cycles 0,2,4; resp_paddr_o 0x1000,0x2000,0x3000 in order, no exception.
- resp_ready_i=0, DEPTH=4, 6 requests -> exactly 4 accepted, req_ready_o=0 with count 4; releasing ready drains 4 in order, then remaining 2 accepted.
- MMU returns exception.valid=1, cause LOAD_PAGE_FAULT on 2nd request -> entry at FIFO with cause 13, halted_o=1, req_ready_o=0; flush_i -> FIFO empty, IDLE, ready=1.
- MMU silent for TIMEOUT=64 cycles -> timeout_o=1 at cycle 64 after request, HALT, no entry pushed; flush_i clears timeout_o.
- flush_i in WAIT, MMU valid next cycle -> result discarded, resp_valid_o stays 0, back to IDLE.
- Bypass, vaddr 0xDEAD_B000 -> no mmu_req_o, resp_paddr_o=0xDEAD_B000 next cycle; rst_i mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/xlat_req_queue.sv
`default_nettype none
// xlat_req_queue: one-outstanding MMU translation requester with an in-order result FIFO,
// halt on fault/timeout until flushed, and a bypass path. Exception vector is {cause, tval, valid}.
module xlat_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int VLEN    = 64,
  parameter int PLEN    = 56,
  parameter int XLEN    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_translation_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [VLEN-1:0]   req_vaddr_i,
  input  logic              req_is_store_i,
  output logic              mmu_req_o,
  output logic [VLEN-1:0]   mmu_vaddr_o,
  output logic              mmu_is_store_o,
  input  logic              mmu_valid_i,
  input  logic [PLEN-1:0]   mmu_paddr_i,
  input  logic [2*XLEN:0]   mmu_exception_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [PLEN-1:0]   resp_paddr_o,
  output logic [2*XLEN:0]   resp_exception_o,
  output logic              halted_o,
  output logic              timeout_o
);

  localparam int EXC_W = 2 * XLEN + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nxt;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              timeout_q;
  logic [VLEN-1:0]   pend_vaddr;
  logic              pend_is_store;

  logic [PLEN-1:0]   paddr_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem   [DEPTH];

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              expired;
  logic              set_timeout;
  logic              not_empty;
  logic [PLEN-1:0]   push_paddr;
  logic [EXC_W-1:0]  push_exc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign not_empty    = (count != '0);
  assign expired      = (timer == TIMER_MAX);
  assign req_ready_o  = ~rst_i & (state == S_IDLE) & (count < DEPTH_C) & ~flush_i;
  assign accept       = req_valid_i & req_ready_o;
  assign mmu_req_o    = issue;
  // Hold the issued address/type stable while the request is outstanding.
  assign mmu_vaddr_o    = (state == S_IDLE) ? req_vaddr_i : pend_vaddr;
  assign mmu_is_store_o = (state == S_IDLE) ? req_is_store_i : pend_is_store;

  assign resp_valid_o     = ~rst_i & not_empty;
  assign resp_paddr_o     = resp_valid_o ? paddr_mem[rd_ptr] : '0;
  assign resp_exception_o = resp_valid_o ? exc_mem[rd_ptr] : '0;
  assign pop              = resp_valid_o & resp_ready_i;
  assign halted_o         = ~rst_i & (state == S_HALT);
  assign timeout_o        = timeout_q;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    issue       = 1'b0;
    push        = 1'b0;
    push_paddr  = '0;
    push_exc    = '0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (accept) begin
          if (en_translation_i) begin
            issue     = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            push       = 1'b1;
            push_paddr = req_vaddr_i[PLEN-1:0];
          end
        end
      end
      S_WAIT: begin
        timer_nxt = timer + 1'b1;
        if (flush_i) begin
          // A response or expiry coinciding with the flush already retires the request.
          state_nxt = (mmu_valid_i | expired) ? S_IDLE : S_FLUSH;
        end else if (mmu_valid_i) begin
          push       = 1'b1;
          push_paddr = mmu_paddr_i;
          push_exc   = mmu_exception_i;
          state_nxt  = mmu_exception_i[0] ? S_HALT : S_IDLE;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_nxt   = S_HALT;
        end
      end
      S_HALT: begin
        if (flush_i) state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        timer_nxt = timer + 1'b1;
        if (mmu_valid_i | expired) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      timer         <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      timeout_q     <= 1'b0;
      pend_vaddr    <= '0;
      pend_is_store <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (flush_i) begin
        timeout_q <= 1'b0;
      end else if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if (issue) begin
        pend_vaddr    <= req_vaddr_i;
        pend_is_store <= req_is_store_i;
      end
      if (flush_i) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push & ~pop) begin
          count <= count + 1'b1;
        end else if (pop & ~push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push & ~flush_i & ~rst_i) begin
      paddr_mem[wr_ptr] <= push_paddr;
      exc_mem[wr_ptr]   <= push_exc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xlat_req_queue.sv
`default_nettype none
// Bench for xlat_req_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_xlat_req_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int VLEN    = 64;
  localparam int PLEN    = 56;
  localparam int XLEN    = 64;
  localparam int EW      = 2 * XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            en_translation_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [VLEN-1:0] req_vaddr_i = '0;
  logic            req_is_store_i = 1'b0;
  logic            mmu_req_o;
  logic [VLEN-1:0] mmu_vaddr_o;
  logic            mmu_is_store_o;
  logic            mmu_valid_i = 1'b0;
  logic [PLEN-1:0] mmu_paddr_i = '0;
  logic [EW-1:0]   mmu_exception_i = '0;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b0;
  logic [PLEN-1:0] resp_paddr_o;
  logic [EW-1:0]   resp_exception_o;
  logic            halted_o;
  logic            timeout_o;

  int checks = 0;
  int failures = 0;

  xlat_req_queue #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .VLEN(VLEN), .PLEN(PLEN), .XLEN(XLEN)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_translation_i(en_translation_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
    .req_is_store_i(req_is_store_i), .mmu_req_o(mmu_req_o), .mmu_vaddr_o(mmu_vaddr_o),
    .mmu_is_store_o(mmu_is_store_o), .mmu_valid_i(mmu_valid_i), .mmu_paddr_i(mmu_paddr_i),
    .mmu_exception_i(mmu_exception_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_paddr_o(resp_paddr_o), .resp_exception_o(resp_exception_o), .halted_o(halted_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    req_valid_i = 1'b0; mmu_valid_i = 1'b0; resp_ready_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  // Issue one translated request and answer it from the MMU side on the following cycle.
  task automatic xlat_one(input logic [VLEN-1:0] va, input logic [PLEN-1:0] pa, input logic [EW-1:0] ex);
    int n;
    n = 0;
    req_valid_i = 1'b1; req_vaddr_i = va; en_translation_i = 1'b1;
    #1;
    while (!req_ready_o && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL xlat_one_ready_wait got=0 exp=1"); end
    step();
    req_valid_i = 1'b0;
    mmu_valid_i = 1'b1; mmu_paddr_i = pa; mmu_exception_i = ex;
    step();
    mmu_valid_i = 1'b0; mmu_exception_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b1; en_translation_i = 1'b1; resp_ready_i = 1'b1;
    step(); step();
    #1;
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready_o); end
    checks++; if (mmu_req_o !== 1'b0) begin failures++; $display("FAIL reset_mmu_req got=%b exp=0", mmu_req_o); end
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid_o); end
    checks++; if (halted_o !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted_o); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    checks++; if (resp_paddr_o !== '0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", resp_paddr_o); end
    req_valid_i = 1'b0; resp_ready_i = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_translate_basic();
    logic [VLEN-1:0] v [3];
    logic [PLEN-1:0] pend_pa;
    int sent, got, first_resp;
    bit pend;
    v[0] = 64'h1000; v[1] = 64'h2000; v[2] = 64'h3000;
    sent = 0; got = 0; first_resp = -1; pend = 0; pend_pa = '0;
    clean();
    resp_ready_i = 1'b1; en_translation_i = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      req_valid_i = (sent < 3);
      req_vaddr_i = (sent < 3) ? v[sent] : '0;
      mmu_valid_i = pend; mmu_paddr_i = pend_pa; mmu_exception_i = '0;
      pend = 0;
      #1;
      if (resp_valid_o) begin
        if (first_resp < 0) first_resp = cyc;
        checks++;
        if (got >= 3 || resp_paddr_o !== v[got][PLEN-1:0] || resp_exception_o !== '0) begin
          failures++; $display("FAIL basic_resp idx=%0d got=%h exp=%h", got, resp_paddr_o, v[got % 3][PLEN-1:0]);
        end
        got++;
      end
      if (req_valid_i && req_ready_o) begin
        checks++;
        if (cyc != 2 * sent || mmu_req_o !== 1'b1 || mmu_vaddr_o !== v[sent]) begin
          failures++; $display("FAIL basic_issue idx=%0d cycle=%0d mmu_req=%b exp_cycle=%0d", sent, cyc, mmu_req_o, 2 * sent);
        end
        pend = 1; pend_pa = v[sent][PLEN-1:0];
        sent++;
      end
      step();
    end
    mmu_valid_i = 1'b0; req_valid_i = 1'b0;
    checks++; if (got != 3 || sent != 3) begin failures++; $display("FAIL basic_count got=%0d/%0d exp=3/3", got, sent); end
    checks++; if (first_resp != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", first_resp); end
  endtask

  task automatic test_full();
    logic [PLEN-1:0] pend_pa;
    int sent, got;
    bit pend;
    sent = 0; got = 0; pend = 0; pend_pa = '0;
    clean();
    en_translation_i = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      resp_ready_i = (cyc >= 16);
      req_valid_i = (sent < 6);
      req_vaddr_i = 64'h4000 + 64'(sent) * 64'h1000;
      mmu_valid_i = pend; mmu_paddr_i = pend_pa; mmu_exception_i = '0;
      pend = 0;
      #1;
      if (cyc == 15) begin
        checks++; if (sent != DEPTH) begin failures++; $display("FAIL full_accepted got=%0d exp=%0d", sent, DEPTH); end
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", req_ready_o); end
      end
      if (resp_valid_o && resp_ready_i) begin
        checks++;
        if (resp_paddr_o !== 56'h80_0000_4000 + 56'(got) * 56'h1000) begin
          failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", got, resp_paddr_o, 56'h80_0000_4000 + 56'(got) * 56'h1000);
        end
        got++;
      end
      if (req_valid_i && req_ready_o) begin
        pend = 1; pend_pa = 56'h80_0000_4000 + 56'(sent) * 56'h1000;
        sent++;
      end
      step();
    end
    req_valid_i = 1'b0; mmu_valid_i = 1'b0;
    checks++; if (sent != 6 || got != 6) begin failures++; $display("FAIL full_total got=%0d/%0d exp=6/6", sent, got); end
  endtask

  task automatic test_fault();
    logic [EW-1:0] ex;
    ex = {64'd13, 64'h6000, 1'b1};
    clean();
    xlat_one(64'h5000, 56'h9000, '0);
    xlat_one(64'h6000, 56'hA000, ex);
    req_valid_i = 1'b1; req_vaddr_i = 64'h7000; en_translation_i = 1'b1;
    #1;
    checks++; if (halted_o !== 1'b1) begin failures++; $display("FAIL fault_halted got=%b exp=1", halted_o); end
    checks++; if (req_ready_o !== 1'b0 || mmu_req_o !== 1'b0) begin failures++; $display("FAIL fault_blocked ready=%b mmu_req=%b exp=0/0", req_ready_o, mmu_req_o); end
    checks++; if (resp_paddr_o !== 56'h9000) begin failures++; $display("FAIL fault_head0 got=%h exp=9000", resp_paddr_o); end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    #1;
    checks++;
    if (resp_paddr_o !== 56'hA000 || resp_exception_o[EW-1:XLEN+1] !== 64'd13 || resp_exception_o[0] !== 1'b1) begin
      failures++; $display("FAIL fault_entry paddr=%h cause=%0d valid=%b exp=a000/13/1", resp_paddr_o, resp_exception_o[EW-1:XLEN+1], resp_exception_o[0]);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; req_valid_i = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || halted_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL fault_flush valid=%b halted=%b ready=%b exp=0/0/1", resp_valid_o, halted_o, req_ready_o);
    end
  endtask

  task automatic test_timeout();
    clean();
    req_valid_i = 1'b1; en_translation_i = 1'b1; req_vaddr_i = 64'h8000;
    #1;
    step();
    req_valid_i = 1'b0;
    repeat (TIMEOUT - 1) step();
    checks++; if (timeout_o !== 1'b0 || halted_o !== 1'b0) begin failures++; $display("FAIL timeout_early timeout=%b halted=%b exp=0/0", timeout_o, halted_o); end
    step();
    checks++;
    if (timeout_o !== 1'b1 || halted_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL timeout_set timeout=%b halted=%b resp_valid=%b exp=1/1/0", timeout_o, halted_o, resp_valid_o);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    checks++;
    if (timeout_o !== 1'b0 || halted_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL timeout_flush timeout=%b halted=%b ready=%b exp=0/0/1", timeout_o, halted_o, req_ready_o);
    end
  endtask

  task automatic test_flush_wait();
    clean();
    req_valid_i = 1'b1; en_translation_i = 1'b1; req_vaddr_i = 64'h9000;
    #1;
    step();
    req_valid_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; mmu_valid_i = 1'b1; mmu_paddr_i = 56'hBEEF000; mmu_exception_i = '0;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL flushwait_ready got=%b exp=0", req_ready_o); end
    step();
    mmu_valid_i = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++; $display("FAIL flushwait_discard resp_valid=%b ready=%b exp=0/1", resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_bypass_and_reset();
    clean();
    en_translation_i = 1'b0; req_valid_i = 1'b1; req_vaddr_i = 64'hDEAD_B000;
    #1;
    checks++; if (mmu_req_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL bypass_issue mmu_req=%b ready=%b exp=0/1", mmu_req_o, req_ready_o); end
    step();
    req_valid_i = 1'b0;
    #1;
    checks++;
    if (resp_valid_o !== 1'b1 || resp_paddr_o !== 56'hDEAD_B000 || resp_exception_o !== '0) begin
      failures++; $display("FAIL bypass_resp valid=%b paddr=%h exp=1/deadb000", resp_valid_o, resp_paddr_o);
    end
    en_translation_i = 1'b1; req_valid_i = 1'b1; req_vaddr_i = 64'hA000;
    #1;
    step();
    req_valid_i = 1'b0; rst_i = 1'b1;
    step();
    checks++;
    if (req_ready_o !== 1'b0 || mmu_req_o !== 1'b0 || resp_valid_o !== 1'b0 || halted_o !== 1'b0 ||
        timeout_o !== 1'b0 || resp_paddr_o !== '0 || resp_exception_o !== '0) begin
      failures++; $display("FAIL midwait_reset ready=%b req=%b valid=%b halted=%b timeout=%b exp=all0",
                           req_ready_o, mmu_req_o, resp_valid_o, halted_o, timeout_o);
    end
    rst_i = 1'b0; mmu_valid_i = 1'b1; mmu_paddr_i = 56'h1234000;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL midwait_idle_ready got=%b exp=1", req_ready_o); end
    step();
    mmu_valid_i = 1'b0;
    #1;
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL midwait_stale_resp got=%b exp=0", resp_valid_o); end
  endtask

  task automatic test_random();
    logic [PLEN-1:0] qp [$];
    logic [EW-1:0]   qe [$];
    logic [PLEN-1:0] pend_pa;
    logic [EW-1:0]   pend_ex;
    bit outstanding, halted, exp_ready, hs;
    int lat_left;
    outstanding = 0; halted = 0; lat_left = 0; pend_pa = '0; pend_ex = '0;
    clean();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      flush_i = !outstanding && ($urandom_range(0, halted ? 2 : 40) == 0);
      req_valid_i = 1'($urandom_range(0, 1));
      req_vaddr_i = {$urandom, $urandom};
      req_is_store_i = 1'($urandom_range(0, 1));
      en_translation_i = ($urandom_range(0, 2) != 0);
      resp_ready_i = ($urandom_range(0, 2) != 0);
      mmu_valid_i = outstanding && (lat_left == 0);
      mmu_paddr_i = mmu_valid_i ? pend_pa : PLEN'({$urandom, $urandom});
      mmu_exception_i = mmu_valid_i ? pend_ex : EW'({$urandom, $urandom, $urandom, $urandom, $urandom});
      #1;
      exp_ready = !outstanding && !halted && (qp.size() < DEPTH) && !flush_i;
      checks++;
      if (req_ready_o !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready); end
      checks++;
      if (resp_valid_o !== (qp.size() != 0)) begin failures++; $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid_o, qp.size() != 0); end
      if (qp.size() != 0) begin
        checks++;
        if (resp_paddr_o !== qp[0] || resp_exception_o !== qe[0]) begin
          failures++; $display("FAIL rnd_head cyc=%0d paddr=%h exp=%h exc_valid=%b exp=%b", cyc, resp_paddr_o, qp[0], resp_exception_o[0], qe[0][0]);
        end
      end
      hs = exp_ready && req_valid_i;
      checks++;
      if (mmu_req_o !== (hs && en_translation_i)) begin failures++; $display("FAIL rnd_mmu_req cyc=%0d got=%b exp=%b", cyc, mmu_req_o, hs && en_translation_i); end
      if (hs && en_translation_i) begin
        checks++;
        if (mmu_vaddr_o !== req_vaddr_i || mmu_is_store_o !== req_is_store_i) begin
          failures++; $display("FAIL rnd_mmu_addr cyc=%0d got=%h exp=%h", cyc, mmu_vaddr_o, req_vaddr_i);
        end
      end
      if (flush_i) begin
        qp.delete(); qe.delete(); halted = 0;
      end else begin
        if (resp_ready_i && qp.size() != 0) begin void'(qp.pop_front()); void'(qe.pop_front()); end
        if (hs && !en_translation_i) begin qp.push_back(req_vaddr_i[PLEN-1:0]); qe.push_back('0); end
        if (mmu_valid_i) begin
          qp.push_back(pend_pa); qe.push_back(pend_ex);
          outstanding = 0;
          if (pend_ex[0]) halted = 1;
        end
      end
      if (outstanding && lat_left > 0) lat_left--;
      if (hs && en_translation_i) begin
        outstanding = 1;
        lat_left = $urandom_range(0, 2);
        pend_pa = PLEN'({$urandom, $urandom});
        pend_ex = ($urandom_range(0, 15) == 0) ? {64'($urandom_range(0, 1) ? 13 : 15), req_vaddr_i, 1'b1} : '0;
      end
      step();
    end
    flush_i = 1'b0; req_valid_i = 1'b0; mmu_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_translate_basic();
    test_full();
    test_fault();
    test_timeout();
    test_flush_wait();
    test_bypass_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
